// File: rtl/sky130_fd_io__gpiovref_mc_ctrl.sv
// Multi-channel GPIO vref control: per-channel enable/select latching with startup and
// re-settle sequencing. Define SKY130_FD_IO__GPIOVREF_MC_AMUX_MON_EN to build the amux monitor select.
`timescale 1ns/1ps
module sky130_fd_io__gpiovref_mc_ctrl #(
  parameter int NCH            = 4,
  parameter int SELW           = 5,
  parameter int STARTUP_CYCLES = 24,
  parameter int SETTLE_CYCLES  = 8,
  localparam int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_h,
  input  logic                 hld_h_n,
  input  logic                 cfg_wr,
  input  logic [CHW-1:0]       cfg_ch,
  input  logic                 cfg_en,
  input  logic [SELW-1:0]      cfg_sel,
`ifdef SKY130_FD_IO__GPIOVREF_MC_AMUX_MON_EN
  input  logic                 mon_wr,
  input  logic [CHW-1:0]       mon_ch,
  output logic                 amux_mon_en,
  output logic [CHW-1:0]       amux_mon_ch,
`endif
  output logic                 cfg_ack,
  output logic                 cfg_err,
  output logic [NCH-1:0]       ch_en,
  output logic [NCH*SELW-1:0]  ch_sel,
  output logic [NCH-1:0]       ch_ready,
  output logic                 all_ready
);

  localparam int CNT_MAX = (STARTUP_CYCLES > SETTLE_CYCLES) ? STARTUP_CYCLES : SETTLE_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  // Channel count widened by one bit so an out-of-range index can be detected for any NCH.
  localparam logic [CHW:0] NCH_W = (CHW + 1)'(NCH);

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_START  = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  logic                r_enable_meta, r_enable_s;
  logic                r_hld_meta, r_hld_s;
  logic                r_cfg_ack, r_cfg_err, r_all_ready;
  logic [1:0]          r_state [NCH];
  logic [CNTW-1:0]     r_cnt   [NCH];
  logic [NCH-1:0]      r_ch_en, r_ch_ready;
  logic [NCH*SELW-1:0] r_ch_sel;

  logic [1:0]          w_state_nxt [NCH];
  logic [CNTW-1:0]     w_cnt_nxt   [NCH];
  logic [NCH-1:0]      w_en_nxt, w_rdy_nxt;
  logic [NCH*SELW-1:0] w_sel_nxt;
  logic                w_accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable_meta <= 1'b0;
      r_enable_s    <= 1'b0;
      r_hld_meta    <= 1'b0;
      r_hld_s       <= 1'b0;
    end else begin
      r_enable_meta <= enable_h;
      r_enable_s    <= r_enable_meta;
      r_hld_meta    <= hld_h_n;
      r_hld_s       <= r_hld_meta;
    end
  end

  assign w_accept = cfg_wr && r_enable_s && r_hld_s && ({1'b0, cfg_ch} < NCH_W);

  // NOTE: every always_comb output takes its hold value first, so no path leaves a latch.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i]               = r_state[i];
      w_cnt_nxt[i]                 = r_cnt[i];
      w_en_nxt[i]                  = r_ch_en[i];
      w_rdy_nxt[i]                 = r_ch_ready[i];
      w_sel_nxt[i*SELW +: SELW]    = r_ch_sel[i*SELW +: SELW];
      if (!r_enable_s) begin
        w_state_nxt[i]             = ST_OFF;
        w_cnt_nxt[i]               = '0;
        w_en_nxt[i]                = 1'b0;
        w_rdy_nxt[i]               = 1'b0;
        w_sel_nxt[i*SELW +: SELW]  = '0;
      end else begin
        // Counting continues under hold; only configuration is frozen.
        if (r_state[i] == ST_START || r_state[i] == ST_SETTLE) begin
          if (r_cnt[i] == CNTW'(1)) begin
            w_state_nxt[i] = ST_READY;
            w_cnt_nxt[i]   = '0;
            w_rdy_nxt[i]   = 1'b1;
          end else begin
            w_cnt_nxt[i]   = r_cnt[i] - CNTW'(1);
          end
        end
        if (w_accept && cfg_ch == CHW'(i)) begin
          if (!cfg_en) begin
            w_state_nxt[i]             = ST_OFF;
            w_cnt_nxt[i]               = '0;
            w_en_nxt[i]                = 1'b0;
            w_rdy_nxt[i]               = 1'b0;
            w_sel_nxt[i*SELW +: SELW]  = '0;
          end else begin
            case (r_state[i])
              ST_OFF, ST_START: begin
                w_state_nxt[i]            = ST_START;
                w_cnt_nxt[i]              = CNTW'(STARTUP_CYCLES);
                w_en_nxt[i]               = 1'b1;
                w_rdy_nxt[i]              = 1'b0;
                w_sel_nxt[i*SELW +: SELW] = cfg_sel;
              end
              default: begin
                if (cfg_sel != r_ch_sel[i*SELW +: SELW]) begin
                  w_state_nxt[i]            = ST_SETTLE;
                  w_cnt_nxt[i]              = CNTW'(SETTLE_CYCLES);
                  w_rdy_nxt[i]              = 1'b0;
                  w_sel_nxt[i*SELW +: SELW] = cfg_sel;
                end
              end
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= ST_OFF;
        r_cnt[i]   <= '0;
      end
      r_ch_en     <= '0;
      r_ch_ready  <= '0;
      r_ch_sel    <= '0;
      r_cfg_ack   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_all_ready <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_ch_en     <= w_en_nxt;
      r_ch_ready  <= w_rdy_nxt;
      r_ch_sel    <= w_sel_nxt;
      r_cfg_ack   <= w_accept;
      r_cfg_err   <= cfg_wr && !w_accept;
      // Built from registered flags, so it trails ch_ready by one edge.
      r_all_ready <= (|r_ch_en) && ((r_ch_en & r_ch_ready) == r_ch_en);
    end
  end

  assign cfg_ack   = r_cfg_ack;
  assign cfg_err   = r_cfg_err;
  assign ch_en     = r_ch_en;
  assign ch_sel    = r_ch_sel;
  assign ch_ready  = r_ch_ready;
  assign all_ready = r_all_ready;

`ifdef SKY130_FD_IO__GPIOVREF_MC_AMUX_MON_EN
  logic           r_mon_en;
  logic [CHW-1:0] r_mon_ch;
  logic [NCH-1:0] w_went_off;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_went_off[i] = (r_state[i] != ST_OFF) && (w_state_nxt[i] == ST_OFF);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon_en <= 1'b0;
      r_mon_ch <= '0;
    end else if (!r_enable_s) begin
      r_mon_en <= 1'b0;
    end else if (mon_wr && ({1'b0, mon_ch} < NCH_W)) begin
      r_mon_en <= 1'b1;
      r_mon_ch <= mon_ch;
    end else if (mon_wr) begin
      r_mon_en <= 1'b0;
    end else if (w_went_off[r_mon_ch]) begin
      r_mon_en <= 1'b0;
    end
  end

  assign amux_mon_en = r_mon_en;
  assign amux_mon_ch = r_mon_ch;
`endif

endmodule

// File: tb/tb_sky130_fd_io__gpiovref_mc_ctrl.sv
// Scoreboard bench: stimulus queues expected ack/err pulses and ready-rise cycles; a negedge monitor matches them.
`timescale 1ns/1ps
module tb_sky130_fd_io__gpiovref_mc_ctrl;

  localparam int NCH = 4;
  localparam int SELW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable_h = 1'b0;
  logic hld_h_n = 1'b0;
  logic cfg_wr = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic cfg_en = 1'b0;
  logic [SELW-1:0] cfg_sel = '0;
  logic cfg_ack, cfg_err, all_ready;
  logic [NCH-1:0] ch_en, ch_ready;
  logic [NCH*SELW-1:0] ch_sel;

  // Three-channel instance: lets an index past the last channel be expressed in the port width.
  logic cfg_wr3 = 1'b0;
  logic [1:0] cfg_ch3 = '0;
  logic cfg_ack3, cfg_err3, all_ready3;
  logic [2:0] ch_en3, ch_ready3;
  logic [3*SELW-1:0] ch_sel3;

  sky130_fd_io__gpiovref_mc_ctrl dut (
    .clk(clk), .reset(reset), .enable_h(enable_h), .hld_h_n(hld_h_n),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .ch_en(ch_en), .ch_sel(ch_sel),
    .ch_ready(ch_ready), .all_ready(all_ready)
  );

  sky130_fd_io__gpiovref_mc_ctrl #(.NCH(3)) dut3 (
    .clk(clk), .reset(reset), .enable_h(enable_h), .hld_h_n(hld_h_n),
    .cfg_wr(cfg_wr3), .cfg_ch(cfg_ch3), .cfg_en(1'b1), .cfg_sel(5'h0a),
    .cfg_ack(cfg_ack3), .cfg_err(cfg_err3), .ch_en(ch_en3), .ch_sel(ch_sel3),
    .ch_ready(ch_ready3), .all_ready(all_ready3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_ack; int cyc; } resp_t;
  typedef struct { int ch; int cyc; } rdy_t;
  resp_t resp_q[$];
  rdy_t  rdy_q[$];

  int errors = 0;
  int checks = 0;
  logic [NCH-1:0] prev_rdy = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack/err pulse and every ready rise must match a queued expectation.
  always @(negedge clk) begin
    if (cfg_ack || cfg_err) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: got ack=%0b err=%0b expected no pulse (cycle %0d)", cfg_ack, cfg_err, cyc);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_ack", {63'd0, cfg_ack}, {63'd0, e.is_ack});
        check("resp_err", {63'd0, cfg_err}, {63'd0, !e.is_ack});
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (ch_ready[i] && !prev_rdy[i]) begin
        int idx;
        idx = -1;
        foreach (rdy_q[k]) if (idx < 0 && rdy_q[k].ch == i) idx = k;
        if (idx < 0) begin
          checks++; errors++;
          $display("FAIL ready_unexpected: ch%0d rose at cycle %0d expected no rise", i, cyc);
        end else begin
          check("ready_rise_cycle", 64'(cyc), 64'(rdy_q[idx].cyc));
          rdy_q.delete(idx);
        end
      end
    end
    prev_rdy = ch_ready;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one write at the next edge; queue its response and, if given, the ready-rise edge.
  task automatic wr(input int ch, input bit en, input logic [SELW-1:0] sel,
                    input bit exp_ack, input int rdy_delay);
    resp_t r;
    rdy_t  d;
    cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_en = en; cfg_sel = sel;
    r.is_ack = exp_ack; r.cyc = cyc + 1;
    resp_q.push_back(r);
    if (rdy_delay > 0) begin
      d.ch = ch; d.cyc = cyc + 1 + rdy_delay;
      rdy_q.push_back(d);
    end
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  function automatic logic [SELW-1:0] sel_of(input int ch);
    return ch_sel[ch*SELW +: SELW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_ch_en", 64'(ch_en), 64'd0);
    check("rst_ch_sel", 64'(ch_sel), 64'd0);
    check("rst_ch_ready", 64'(ch_ready), 64'd0);
    check("rst_all_ready", {63'd0, all_ready}, 64'd0);
    check("rst_ack_err", {62'd0, cfg_ack, cfg_err}, 64'd0);

    reset = 1'b0;
    enable_h = 1'b1; hld_h_n = 1'b1;
    tick(1);
    wr(2, 1'b1, 5'h13, 1'b0, 0);                 // synchronisers not settled yet
    check("early_wr_no_state", 64'(ch_en), 64'd0);
    wr(2, 1'b1, 5'h13, 1'b1, 24);
    check("ch2_en", {63'd0, ch_en[2]}, 64'd1);
    check("ch2_sel", 64'(sel_of(2)), 64'h13);
    check("ch2_not_ready_at_accept", {63'd0, ch_ready[2]}, 64'd0);
    tick(23);
    check("ch2_ready_before_24", {63'd0, ch_ready[2]}, 64'd0);
    tick(1);
    check("ch2_ready_at_24", {63'd0, ch_ready[2]}, 64'd1);
    check("all_ready_lags", {63'd0, all_ready}, 64'd0);
    tick(1);
    check("all_ready_set", {63'd0, all_ready}, 64'd1);

    wr(2, 1'b1, 5'h07, 1'b1, 8);                 // reselect: drop and settle
    check("ch2_drop_on_resel", {63'd0, ch_ready[2]}, 64'd0);
    check("ch2_sel_new", 64'(sel_of(2)), 64'h07);
    tick(7);
    check("ch2_settling", {63'd0, ch_ready[2]}, 64'd0);
    tick(1);
    check("ch2_settled", {63'd0, ch_ready[2]}, 64'd1);
    wr(2, 1'b1, 5'h07, 1'b1, 0);                 // same select: ack only
    check("ch2_same_sel_ready", {63'd0, ch_ready[2]}, 64'd1);
    tick(2);
    check("ch2_same_sel_hold", {63'd0, ch_ready[2]}, 64'd1);

    wr(0, 1'b1, 5'h03, 1'b1, 24);
    tick(2);
    hld_h_n = 1'b0;
    tick(2);
    wr(0, 1'b0, 5'h00, 1'b0, 0);                 // rejected under hold
    check("hold_en_kept", {63'd0, ch_en[0]}, 64'd1);
    wr(0, 1'b1, 5'h09, 1'b0, 0);
    check("hold_sel_kept", 64'(sel_of(0)), 64'h03);
    check("other_ch_untouched", 64'(sel_of(2)), 64'h07);
    tick(17);
    check("hold_ch0_pending", {63'd0, ch_ready[0]}, 64'd0);
    tick(1);
    check("hold_ch0_ready", {63'd0, ch_ready[0]}, 64'd1);
    hld_h_n = 1'b1;
    tick(3);

    cfg_wr3 = 1'b1; cfg_ch3 = 2'd3;              // past last channel of the 3-channel instance
    tick(1);
    cfg_wr3 = 1'b0;
    check("oob_err", {62'd0, cfg_err3, cfg_ack3}, 64'b10);
    check("oob_no_state", 64'(ch_en3), 64'd0);
    cfg_wr3 = 1'b1; cfg_ch3 = 2'd2;
    tick(1);
    cfg_wr3 = 1'b0;
    check("inrange_ack", {62'd0, cfg_err3, cfg_ack3}, 64'b01);
    check("inrange_en", 64'(ch_en3), 64'b100);

    wr(1, 1'b1, 5'h01, 1'b1, 24);
    tick(24);
    wr(1, 1'b1, 5'h02, 1'b1, 0);                 // ch1 to SETTLE; disable pre-empts it
    enable_h = 1'b0;
    tick(2);
    check("dis_not_yet", 64'(ch_en), 64'b0111);
    tick(1);
    check("dis_ch_en", 64'(ch_en), 64'd0);
    check("dis_ch_sel", 64'(ch_sel), 64'd0);
    check("dis_ch_ready", 64'(ch_ready), 64'd0);
    tick(1);
    check("dis_all_ready", {63'd0, all_ready}, 64'd0);
    wr(0, 1'b1, 5'h01, 1'b0, 0);                 // rejected while disabled
    check("dis_wr_no_state", 64'(ch_en), 64'd0);

    enable_h = 1'b1;
    tick(3);
    wr(3, 1'b1, 5'h1f, 1'b1, 0);
    tick(5);
    reset = 1'b1;
    #1;
    check("rst_mid_en", 64'(ch_en), 64'd0);
    tick(2);
    reset = 1'b0;
    tick(30);
    check("rst_mid_ready", 64'(ch_ready), 64'd0);
    check("rst_mid_en_after", 64'(ch_en), 64'd0);

    check("resp_q_drained", 64'(resp_q.size()), 64'd0);
    check("rdy_q_drained", 64'(rdy_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
